// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes (common with the control-unit decoder),
// loader instruction-class codes, error codes and loader FSM states.
package rv32i_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [3:0] CLS_R      = 4'd0;
  localparam logic [3:0] CLS_I_ALU  = 4'd1;
  localparam logic [3:0] CLS_LOAD   = 4'd2;
  localparam logic [3:0] CLS_STORE  = 4'd3;
  localparam logic [3:0] CLS_BRANCH = 4'd4;
  localparam logic [3:0] CLS_JALR   = 4'd5;
  localparam logic [3:0] CLS_JAL    = 4'd6;
  localparam logic [3:0] CLS_LUI    = 4'd7;
  localparam logic [3:0] CLS_AUIPC  = 4'd8;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ILLEGAL  = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_OVERFLOW = 2'b11
  } err_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  // True when v is representable as a two's-complement value of 'bits' width.
  function automatic logic fits_simm(input logic [31:0] v, input int unsigned bits);
    logic [31:0] hi_mask;
    hi_mask = 32'hFFFF_FFFF << (bits - 32'd1);
    return ((v & hi_mask) == 32'd0) || ((v & hi_mask) == hi_mask);
  endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Combinational RV32I word assembly: picks the format for the class, packs the
// immediate and flags illegal classes and out-of-range immediates.
module rv32i_imm_pack
  import rv32i_pkg::*;
(
  input  logic [3:0]  class_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7_b5_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o,
  output logic        range_err_o
);

  logic fits12_s;
  logic fits13_s;
  logic fits21_s;

  assign fits12_s = fits_simm(imm_i, 32'd12);
  assign fits13_s = fits_simm(imm_i, 32'd13);
  assign fits21_s = fits_simm(imm_i, 32'd21);

  // Format selection and immediate scattering
  always_comb begin
    word_o      = 32'd0;
    illegal_o   = 1'b0;
    range_err_o = 1'b0;
    case (class_i)
      CLS_R: begin
        word_o = {1'b0, funct7_b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, R_TYPE};
      end
      CLS_I_ALU: begin
        // Shifts reuse the upper immediate bits as a funct7 field
        if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
          word_o      = {1'b0, funct7_b5_i, 5'b00000, imm_i[4:0], rs1_i, funct3_i, rd_i, I_TYPE};
          range_err_o = (imm_i[31:5] != 27'd0);
        end else begin
          word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, I_TYPE};
          range_err_o = ~fits12_s;
        end
      end
      CLS_LOAD: begin
        word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, LOAD};
        range_err_o = ~fits12_s;
      end
      CLS_STORE: begin
        word_o      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], STORE};
        range_err_o = ~fits12_s;
      end
      CLS_BRANCH: begin
        word_o      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], BRANCH};
        range_err_o = ~fits13_s | imm_i[0];
      end
      CLS_JALR: begin
        word_o      = {imm_i[11:0], rs1_i, 3'b000, rd_i, JALR};
        range_err_o = ~fits12_s;
      end
      CLS_JAL: begin
        word_o      = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, JAL};
        range_err_o = ~fits21_s | imm_i[0];
      end
      CLS_LUI: begin
        word_o      = {imm_i[31:12], rd_i, LUI};
        range_err_o = (imm_i[11:0] != 12'd0);
      end
      CLS_AUIPC: begin
        word_o      = {imm_i[31:12], rd_i, AUIPC};
        range_err_o = (imm_i[11:0] != 12'd0);
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Program loader: accepts field-level instruction descriptions, encodes them and
// writes them sequentially into instruction memory with done/error reporting.
module rv32i_instr_encoder
  import rv32i_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_b5,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE      = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};

  state_e            state_q;
  err_code_e         code_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              done_q;
  logic              err_q;

  logic [31:0]       word_s;
  logic              illegal_s;
  logic              range_err_s;

  rv32i_imm_pack u_imm_pack (
    .class_i     (in_class),
    .rd_i        (in_rd),
    .rs1_i       (in_rs1),
    .rs2_i       (in_rs2),
    .funct3_i    (in_funct3),
    .funct7_b5_i (in_funct7_b5),
    .imm_i       (in_imm),
    .word_o      (word_s),
    .illegal_o   (illegal_s),
    .range_err_o (range_err_s)
  );

  assign addr_d  = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};

  // start overrides the stream, so a coincident in_valid is never taken
  assign in_ready = (state_q == S_LOAD) && !start;

  // Loader FSM with registered write port and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= BASE;
      imem_addr_q <= BASE;
      count_q     <= {(ADDR_W+1){1'b0}};
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
    end else if (start) begin
      state_q     <= S_LOAD;
      addr_q      <= BASE;
      imem_addr_q <= BASE;
      count_q     <= {(ADDR_W+1){1'b0}};
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            if (illegal_s) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              code_q  <= ERR_ILLEGAL;
            end else if (range_err_s) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              code_q  <= ERR_RANGE;
            end else begin
              we_q        <= 1'b1;
              imem_addr_q <= addr_q;
              wdata_q     <= word_s;
              addr_q      <= addr_d;
              count_q     <= count_d;
              if (in_last) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else if (count_q == LAST_SLOT) begin
                // Final slot used but the program claims more words follow
                state_q <= S_ERR;
                err_q   <= 1'b1;
                code_q  <= ERR_OVERFLOW;
              end else begin
                state_q <= S_LOAD;
              end
            end
          end else begin
            state_q <= S_LOAD;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = wdata_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Bench for rv32i_instr_encoder: two instances (256-word and 4-word memories)
// checked every cycle against a field-level reference model, plus directed vectors.
module tb_rv32i_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, st, vl, lst, f7;
  logic [3:0]  cls;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm;

  logic        rdy0, we0, done0, err0, rdy1, we1, done1, err1;
  logic [7:0]  addr0;
  logic [1:0]  addr1, code0, code1;
  logic [8:0]  cnt0;
  logic [2:0]  cnt1;
  logic [31:0] wdata0, wdata1;

  logic [31:0] g_rdy[2], g_we[2], g_addr[2], g_wdata[2], g_done[2], g_err[2], g_code[2], g_cnt[2];

  int errors = 0;
  int checks = 0;

  int m_state[2], m_addr[2], m_cnt[2], m_done[2], m_err[2], m_code[2], m_we[2];
  logic [31:0] m_waddr[2], m_wdata[2];
  int cap[2] = '{256, 4};
  int bnd[16] = '{2047, -2048, 2048, -2049, 4094, -4096, 4096, -4098,
                  3, 1048574, -1048576, 1048576, 31, 32, 4096, 4097};

  rv32i_instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(st), .in_valid(vl), .in_ready(rdy0),
    .in_class(cls), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_funct3(f3),
    .in_funct7_b5(f7), .in_imm(imm), .in_last(lst), .imem_we(we0),
    .imem_addr(addr0), .imem_wdata(wdata0), .done(done0), .err(err0),
    .err_code(code0), .word_count(cnt0));

  rv32i_instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut1 (
    .clk(clk), .rst(rst), .start(st), .in_valid(vl), .in_ready(rdy1),
    .in_class(cls), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_funct3(f3),
    .in_funct7_b5(f7), .in_imm(imm), .in_last(lst), .imem_we(we1),
    .imem_addr(addr1), .imem_wdata(wdata1), .done(done1), .err(err1),
    .err_code(code1), .word_count(cnt1));

  assign g_rdy[0] = 32'(rdy0);    assign g_rdy[1] = 32'(rdy1);
  assign g_we[0] = 32'(we0);      assign g_we[1] = 32'(we1);
  assign g_addr[0] = 32'(addr0);  assign g_addr[1] = 32'(addr1);
  assign g_wdata[0] = wdata0;     assign g_wdata[1] = wdata1;
  assign g_done[0] = 32'(done0);  assign g_done[1] = 32'(done1);
  assign g_err[0] = 32'(err0);    assign g_err[1] = 32'(err1);
  assign g_code[0] = 32'(code0);  assign g_code[1] = 32'(code1);
  assign g_cnt[0] = 32'(cnt0);    assign g_cnt[1] = 32'(cnt1);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference encoder: builds the word by shifting each field into place.
  function automatic void ref_encode(input logic [3:0] c, input logic [31:0] i,
                                     output logic [31:0] w, output int code);
    longint s;
    logic [31:0] rdw, r1w, r2w, f3w, f7w;
    s = longint'($signed(i));
    rdw = 32'(rd); r1w = 32'(rs1); r2w = 32'(rs2); f3w = 32'(f3); f7w = 32'(f7);
    w = 32'd0;
    code = 0;
    case (c)
      4'd0: w = 32'h33 | rdw << 7 | f3w << 12 | r1w << 15 | r2w << 20 | f7w << 30;
      4'd1: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if (s < 0 || s > 31) code = 2;
          w = 32'h13 | rdw << 7 | f3w << 12 | r1w << 15 | (i & 32'd31) << 20 | f7w << 30;
        end else begin
          if (s < -2048 || s > 2047) code = 2;
          w = 32'h13 | rdw << 7 | f3w << 12 | r1w << 15 | (i & 32'hFFF) << 20;
        end
      end
      4'd2: begin
        if (s < -2048 || s > 2047) code = 2;
        w = 32'h03 | rdw << 7 | f3w << 12 | r1w << 15 | (i & 32'hFFF) << 20;
      end
      4'd3: begin
        if (s < -2048 || s > 2047) code = 2;
        w = 32'h23 | (i & 32'd31) << 7 | f3w << 12 | r1w << 15 | r2w << 20 | ((i >> 5) & 32'd127) << 25;
      end
      4'd4: begin
        if (s < -4096 || s > 4095 || i[0]) code = 2;
        w = 32'h63 | ((i >> 11) & 32'd1) << 7 | ((i >> 1) & 32'd15) << 8 | f3w << 12 | r1w << 15
            | r2w << 20 | ((i >> 5) & 32'd63) << 25 | ((i >> 12) & 32'd1) << 31;
      end
      4'd5: begin
        if (s < -2048 || s > 2047) code = 2;
        w = 32'h67 | rdw << 7 | r1w << 15 | (i & 32'hFFF) << 20;
      end
      4'd6: begin
        if (s < -1048576 || s > 1048575 || i[0]) code = 2;
        w = 32'h6F | rdw << 7 | ((i >> 12) & 32'd255) << 12 | ((i >> 11) & 32'd1) << 20
            | ((i >> 1) & 32'd1023) << 21 | ((i >> 20) & 32'd1) << 31;
      end
      4'd7, 4'd8: begin
        if ((i & 32'hFFF) != 32'd0) code = 2;
        w = (i & 32'hFFFF_F000) | rdw << 7 | ((c == 4'd7) ? 32'h37 : 32'h17);
      end
      default: code = 1;
    endcase
  endfunction

  task automatic model_reset(input int k);
    m_state[k] = 0; m_addr[k] = 0; m_cnt[k] = 0; m_done[k] = 0;
    m_err[k] = 0; m_code[k] = 0; m_we[k] = 0;
  endtask

  // One clock: check in_ready, advance the model, then check registered outputs.
  task automatic tick();
    logic [31:0] w;
    int code;
    bit acc;
    #1;
    ref_encode(cls, imm, w, code);
    for (int k = 0; k < 2; k++) begin
      acc = (m_state[k] == 1) && !st;
      chk($sformatf("in_ready%0d", k), g_rdy[k], acc ? 32'd1 : 32'd0);
      acc = acc && vl;
      if (rst) begin
        model_reset(k);
      end else if (st) begin
        model_reset(k);
        m_state[k] = 1;
      end else begin
        m_we[k] = 0;
        if (acc) begin
          if (code != 0) begin
            m_state[k] = 3; m_err[k] = 1; m_code[k] = code;
          end else begin
            m_we[k] = 1; m_waddr[k] = 32'(m_addr[k]); m_wdata[k] = w;
            m_addr[k] = (m_addr[k] + 1) % cap[k];
            if (lst) begin
              m_state[k] = 2; m_done[k] = 1;
            end else if (m_cnt[k] == cap[k] - 1) begin
              m_state[k] = 3; m_err[k] = 1; m_code[k] = 3;
            end
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("we%0d", k), g_we[k], 32'(m_we[k]));
      chk($sformatf("done%0d", k), g_done[k], 32'(m_done[k]));
      chk($sformatf("err%0d", k), g_err[k], 32'(m_err[k]));
      chk($sformatf("err_code%0d", k), g_code[k], 32'(m_code[k]));
      chk($sformatf("word_count%0d", k), g_cnt[k], 32'(m_cnt[k]));
      if (m_we[k] != 0) begin
        chk($sformatf("addr%0d", k), g_addr[k], m_waddr[k]);
        chk($sformatf("wdata%0d", k), g_wdata[k], m_wdata[k]);
      end
      if (rst) begin
        chk($sformatf("rst_addr%0d", k), g_addr[k], 32'd0);
        chk($sformatf("rst_wdata%0d", k), g_wdata[k], 32'd0);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    st = 1'b0; vl = 1'b0; lst = 1'b0; rst = 1'b0;
  endtask

  task automatic put(input logic [3:0] c, input logic [4:0] d, input logic [4:0] a,
                     input logic [4:0] b, input logic [2:0] fn3, input logic fn7,
                     input logic [31:0] i, input logic last);
    st = 1'b0; vl = 1'b1; rst = 1'b0;
    cls = c; rd = d; rs1 = a; rs2 = b; f3 = fn3; f7 = fn7; imm = i; lst = last;
  endtask

  task automatic do_start();
    idle(); st = 1'b1; tick(); st = 1'b0;
  endtask

  function automatic logic [31:0] rand_imm(input logic [3:0] c);
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return $urandom;
    if (r == 1) return bnd[$urandom_range(0, 15)];
    case (c)
      4'd1: return (f3 == 3'd1 || f3 == 3'd5) ? 32'($urandom_range(0, 31))
                                              : 32'(int'($urandom_range(0, 4095)) - 2048);
      4'd2, 4'd3, 4'd5: return 32'(int'($urandom_range(0, 4095)) - 2048);
      4'd4: return 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
      4'd6: return 32'((int'($urandom_range(0, 1048575)) - 524288) * 2);
      4'd7, 4'd8: return $urandom & 32'hFFFF_F000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle();
    cls = 4'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; f3 = 3'd0; f7 = 1'b0; imm = 32'd0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset(0); model_reset(1);
    tick();
    idle();
    tick();

    // ADDI x1,x0,5 as a one-word program
    do_start();
    put(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b1); tick();
    chk("addi_we", g_we[0], 32'd1);
    chk("addi_wdata", g_wdata[0], 32'h0050_0093);
    chk("addi_done", g_done[0], 32'd1);
    idle(); tick();

    // Back-to-back stream
    do_start();
    put(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0); tick();
    chk("add_wdata", g_wdata[0], 32'h0020_81B3);
    put(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0); tick();
    chk("sub_wdata", g_wdata[0], 32'h4020_81B3);
    put(4'd1, 5'd5, 5'd5, 5'd0, 3'd5, 1'b1, 32'd3, 1'b0); tick();
    chk("srai_wdata", g_wdata[0], 32'h4032_D293);
    put(4'd7, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 1'b1); tick();
    chk("lui_wdata", g_wdata[0], 32'h1234_5137);
    chk("lui_addr", g_addr[0], 32'd3);
    idle(); tick();

    // Branch and jump
    do_start();
    put(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4, 1'b0); tick();
    chk("beq_wdata", g_wdata[0], 32'hFE20_8EE3);
    put(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b1); tick();
    chk("jal_wdata", g_wdata[0], 32'h0080_00EF);
    idle(); tick();

    // Range error, illegal class, start clears
    do_start();
    put(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 1'b0); tick();
    chk("range_code", g_code[0], 32'd2);
    tick();
    do_start();
    put(4'd12, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048, 1'b0); tick();
    chk("illegal_code", g_code[0], 32'd1);
    do_start();
    chk("start_clr_err", g_err[0], 32'd0);

    // Overflow on the 4-word instance
    for (int i = 0; i < 4; i++) begin
      put(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'(i), 1'b0); tick();
    end
    chk("ovf_code", g_code[1], 32'd3);
    tick();
    chk("ovf_no_we", g_we[1], 32'd0);
    idle(); tick();

    // start beats in_valid; reset mid-stream
    do_start();
    put(4'd0, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 1'b0); st = 1'b1; tick();
    chk("start_vs_valid", g_cnt[0], 32'd0);
    put(4'd0, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 1'b0); tick();
    rst = 1'b1; tick();
    chk("rst_count", g_cnt[0], 32'd0);
    rst = 1'b0; tick(); tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle();
      rst = ($urandom_range(0, 299) == 0);
      st  = (m_state[0] != 1 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
      vl  = ($urandom_range(0, 3) != 0);
      r   = int'($urandom_range(0, 39));
      cls = (r < 36) ? 4'(r % 9) : 4'(9 + r % 7);
      rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
      f3  = 3'($urandom); f7 = 1'($urandom);
      imm = rand_imm(cls);
      lst = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_instr_encoder.md
Name: rv32i_instr_encoder

Overview:
- Program loader for the pipelined RV32I core: the encoder counterpart to the main control-unit opcode decoder.
- Accepts field-level instruction descriptions over a valid/ready stream.
- Assembles legal 32-bit RV32I words (R/I/S/B/U/J formats, all nine opcode classes the decoder handles) and writes them sequentially into instruction memory.
- Reports done, word count and sticky errors so the core can be released from reset.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity = 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load session; restarts from any state
- in_valid  in  1  instruction description valid
- in_ready  out  1  encoder accepts; transfer when in_valid & in_ready
- in_class  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JALR, 6 JAL, 7 LUI, 8 AUIPC; 9-15 illegal
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_funct3  in  3  funct3 (ignored for JALR, JAL, LUI, AUIPC)
- in_funct7_b5  in  1  instr[30] for R-type and SRAI
- in_imm  in  32  full signed immediate (U-type: full 32-bit value)
- in_last  in  1  final word of program
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write word address
- imem_wdata  out  32  encoded instruction
- done  out  1  session completed normally
- err  out  1  sticky error
- err_code  out  2  00 none, 01 illegal class, 10 immediate range, 11 overflow
- word_count  out  ADDR_W+1  words written this session

Behaviour:
- Clock and reset: one clock clk; synchronous active-high reset rst.
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr BASE_ADDR, imem_wdata 0, done 0, err 0, err_code 00, word_count 0.
- Reset mid-session aborts it; any pending write is dropped.
- FSM states: IDLE, LOAD, DONE, ERR.
  - start in any state -> LOAD next cycle; addr = BASE_ADDR, word_count 0, done/err/err_code cleared.
- in_ready = (state==LOAD) & ~start. start wins over a simultaneous in_valid; that word is not accepted.
- Accept in cycle t:
  - Valid word: imem_we=1 in t+1 only, with imem_addr = current address and imem_wdata = encoded word.
  - word_count and address increment at the same edge.
  - Single-stage, full-throughput: one word per cycle sustained.
- Encoding (opcodes per the shared package):
  - R: {0,f7b5,00000,rs2,rs1,f3,rd,op}.
  - I-ALU: imm[11:0] at [31:20]. If f3 is 001 or 101, [31:25]={0,f7b5,00000}, [24:20]=imm[4:0], and imm must be 0..31.
  - LOAD: I format with funct3 from in_funct3. JALR: I format with funct3 forced 000.
  - STORE: imm[11:5] at [31:25], imm[4:0] at [11:7].
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - LUI/AUIPC: imm[31:12] at [31:12].
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Immediate range rules (violation -> err_code 10):
  - I/S: signed 12-bit, -2048..2047.
  - B: signed 13-bit and even.
  - J: signed 21-bit and even.
  - U: imm[11:0]==0.
- Errors on accepted word (illegal class or range violation):
  - Word not written; ERR in t+1; err=1 and err_code held until start or rst.
  - Illegal class takes priority over range.
- Last word: written in t+1; state DONE in t+1; done=1 held until start or rst.
- Overflow:
  - A non-last word accepted when word_count == 2^ADDR_W-1 is written to the final slot, then ERR with code 11.
  - Filling exactly to capacity with in_last=1 on the final word is legal and ends in DONE.
- in_ready=0 in IDLE, DONE and ERR; in_valid is ignored there.

Decomposition:
- Package rv32i_pkg holds:
  - opcode constants R_TYPE, I_TYPE, LOAD, STORE, BRANCH, JALR, JAL, LUI, AUIPC (shared with the control unit);
  - in_class codes, err_code constants, FSM state encoding.
- Sub-module rv32i_imm_pack: combinational format selection, immediate packing and range/legality check; returns word, illegal, range_err.

Test Plan:
- start; ADDI x1,x0,5 (class 1, rd1, imm 5, last) -> next cycle imem_we=1, addr 0, wdata 0x00500093; done=1, word_count=1.
- Stream without gaps: ADD x3,x1,x2; SUB x3,x1,x2 (f7b5=1); SRAI x5,x5,3; LUI x2,0x12345000 (last) -> addr 0..3 written with wdata 0x002081B3, 0x402081B3, 0x4032D293, 0x12345137; one write per cycle.
- BEQ x1,x2,-4 then JAL x1,+8 (last) -> 0xFE208EE3 at addr 0, 0x008000EF at addr 1.
- ADDI imm=2048 -> no imem_we, err=1, err_code=10, in_ready=0; class 12 after start -> err_code=01; start clears err.
- ADDR_W=2, four non-last words -> addr 0..3 written, then err_code=11, in_ready=0; a fifth in_valid is never accepted.
- start asserted with in_valid, and rst mid-stream -> word not accepted; after rst all outputs at reset values, no further imem_we.
